// File: rtl/ps2_keyboard_rx_if.sv
// Decoded keyboard outputs handed from the PS/2 receiver to the pong system block.
// The receiver drives through master; consumers read through slave.
interface ps2_keyboard_rx_if;
    logic [7:0] current_data;
    logic       extended;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output current_data,
        output extended,
        output code,
        output code_valid,
        output frame_err
    );

    modport slave (
        input current_data,
        input extended,
        input code,
        input code_valid,
        input frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw pins, deframes bytes,
// and tracks the currently held key through E0/F0 prefix sequences.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keyboard_rx_if.master kb
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [1:0]     clk_sync;
    logic [1:0]     data_sync;
    logic           clk_filt;
    logic [FW-1:0]  filt_cnt;
    logic [TW-1:0]  to_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           parity_bit;
    logic           break_pend;
    logic           ext_pend;
    logic [7:0]     current_data_q;
    logic           extended_q;
    logic [7:0]     code_q;
    logic           code_valid_q;
    logic           frame_err_q;
    logic           fall;
    logic           data_bit;
    logic           frame_ok;
    logic           frame_bad;
    logic           timeout_hit;

    // Pins idle high, so the synchronizers and filter come out of reset at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            if (clk_sync[1] != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall     = clk_filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));
    assign data_bit = data_sync[1];

    always_comb begin
        next_state  = state;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        timeout_hit = 1'b0;
        if (fall) begin
            unique case (state)
                IDLE:   if (!data_bit) next_state = DATA;
                DATA:   if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY: next_state = STOP;
                STOP: begin
                    next_state = IDLE;
                    if (data_bit && (^{shreg, parity_bit})) frame_ok  = 1'b1;
                    else                                     frame_bad = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Registered pulse lands TIMEOUT_CYCLES clks after the fall, aligned like code_valid.
            timeout_hit = 1'b1;
            next_state  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            to_cnt         <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            parity_bit     <= 1'b0;
            break_pend     <= 1'b0;
            ext_pend       <= 1'b0;
            current_data_q <= '0;
            extended_q     <= 1'b0;
            code_q         <= '0;
            code_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state        <= next_state;
            code_valid_q <= frame_ok;
            frame_err_q  <= frame_bad || timeout_hit;

            if (fall)               to_cnt <= TW'(1);
            else if (state == IDLE) to_cnt <= '0;
            else                    to_cnt <= to_cnt + 1'b1;

            if (fall && state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shreg   <= {data_bit, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall && state == PARITY) parity_bit <= data_bit;

            if (timeout_hit) begin
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end

            if (frame_ok) begin
                code_q <= shreg;
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    break_pend <= 1'b1;
                end else if (break_pend) begin
                    // A release only clears the key if it names the key being held.
                    if (shreg == current_data_q && ext_pend == extended_q) begin
                        current_data_q <= 8'h00;
                        extended_q     <= 1'b0;
                    end
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                end else begin
                    current_data_q <= shreg;
                    extended_q     <= ext_pend;
                    ext_pend       <= 1'b0;
                end
            end
        end
    end

    assign kb.current_data = current_data_q;
    assign kb.extended     = extended_q;
    assign kb.code         = code_q;
    assign kb.code_valid   = code_valid_q;
    assign kb.frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: stimulus pushes hand-computed expectations,
// a monitor pops them whenever the receiver pulses code_valid or frame_err.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

    localparam int T        = 5000;
    localparam int HALF     = 20;
    localparam int FALL_LAT = 6;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [7:0] cur;
        bit         ext;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk;
    logic ps2_data;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    ps2_keyboard_rx_if kb();

    ps2_keyboard_rx #(
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .kb(kb)
    );

    // 500 kHz system clock; 40-clk PS/2 period gives 12.5 kHz ps2_clk.
    always #1000 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input bit stop_v,
                                  input bit exp_err, input logic [7:0] exp_code,
                                  input logic [7:0] exp_cur, input bit exp_ext);
        logic par;
        exp_t e;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = stop_v;
        wait_clks(HALF);
        e = '{exp_err, exp_code, exp_cur, exp_ext, cyc + FALL_LAT};
        sb.push_back(e);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 2 * T) begin
            wait_clks(1);
            w++;
        end
        check_output(name, sb.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] code_e,
                                      input logic [7:0] cur_e, input bit ext_e);
        check_output({tag, "_code"}, kb.code, code_e);
        check_output({tag, "_cur"}, kb.current_data, cur_e);
        check_output({tag, "_ext"}, kb.extended, ext_e);
        check_output({tag, "_valid"}, kb.code_valid, 0);
        check_output({tag, "_err"}, kb.frame_err, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check_output("pulse_overlap", kb.code_valid & kb.frame_err, 0);
            if (kb.code_valid === 1'b1 || kb.frame_err === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_pulse", {kb.code_valid, kb.frame_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("pulse_kind_err", kb.frame_err, e.is_err);
                    check_output("code", kb.code, e.code);
                    check_output("current_data", kb.current_data, e.cur);
                    check_output("extended", kb.extended, e.ext);
                    check_output("latency_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #200_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        exp_t e;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(4);
        check_idle_outputs("reset", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        wait_clks(10);

        // Make, break, re-make, foreign break, extended make and extended break.
        apply_stimulus(8'h1D, 0, 1, 0, 8'h1D, 8'h1D, 0);
        apply_stimulus(8'hF0, 0, 1, 0, 8'hF0, 8'h1D, 0);
        apply_stimulus(8'h1D, 0, 1, 0, 8'h1D, 8'h00, 0);
        apply_stimulus(8'h1D, 0, 1, 0, 8'h1D, 8'h1D, 0);
        apply_stimulus(8'hF0, 0, 1, 0, 8'hF0, 8'h1D, 0);
        apply_stimulus(8'h1B, 0, 1, 0, 8'h1B, 8'h1D, 0);
        apply_stimulus(8'hE0, 0, 1, 0, 8'hE0, 8'h1D, 0);
        apply_stimulus(8'h75, 0, 1, 0, 8'h75, 8'h75, 1);
        apply_stimulus(8'hE0, 0, 1, 0, 8'hE0, 8'h75, 1);
        apply_stimulus(8'hF0, 0, 1, 0, 8'hF0, 8'h75, 1);
        apply_stimulus(8'h75, 0, 1, 0, 8'h75, 8'h00, 0);

        // Bad parity, then bad stop bit: error pulses, code left at 0x75.
        apply_stimulus(8'h1B, 1, 1, 1, 8'h75, 8'h00, 0);
        apply_stimulus(8'h1B, 0, 0, 1, 8'h75, 8'h00, 0);
        drain("drain_errors");

        // Partial frame abandoned by the timeout.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        e = '{1'b1, 8'h75, 8'h00, 1'b0, last_fall_cyc + FALL_LAT - 1 + T};
        sb.push_back(e);
        wait_clks(T + 20);
        drain("drain_timeout");
        apply_stimulus(8'h1D, 0, 1, 0, 8'h1D, 8'h1D, 0);

        // Short low glitch on ps2_clk while idle must not start a frame.
        ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(20);
        check_idle_outputs("glitch", 8'h1D, 8'h1D, 1'b0);
        apply_stimulus(8'hE0, 0, 1, 0, 8'hE0, 8'h1D, 0);
        drain("drain_glitch");

        // Reset mid-frame clears everything, including the pending E0.
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        reset = 1'b1;
        wait_clks(3);
        check_idle_outputs("midreset", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        wait_clks(10);
        apply_stimulus(8'h1B, 0, 1, 0, 8'h1B, 8'h1B, 0);

        drain("drain_final");
        wait_clks(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Upstream input stage for the pong system. It receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes make, break (F0) and extended (E0) sequences. It presents the currently held key on current_data, which feeds the system block's 8-bit current_data input. It runs in the same clk domain as the framerate clock source (VGA_CLK).

Parameters:
FILTER_LEN, 4, clk cycles the synchronized ps2_clk must hold a new level before the change is accepted (glitch filter).
TIMEOUT_CYCLES, 5000, clk cycles without an accepted ps2_clk falling edge before a partial frame is abandoned (~200 us at 25 MHz).

Ports:
clk  input  1  system clock (VGA_CLK domain)
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
current_data  output  8  scan code of the currently held key; 0x00 when no key is held
extended  output  1  1 when the current_data key arrived with an E0 prefix
code  output  8  last complete frame byte received, raw
code_valid  output  1  one-cycle pulse when code updates
frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-high. All outputs are 0. State is IDLE, the bit counter is 0, and the break_pend and ext_pend flags are 0. Reset asserted mid-frame discards the partial frame with no pulses.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - Filtered ps2_clk changes only after the synchronized value differs from it for FILTER_LEN consecutive clks.
  - A "fall" is a 1->0 change of filtered ps2_clk; the synchronized ps2_data is sampled on that cycle.
- Frame format: start bit 0, data bits D0..D7 LSB first, odd parity bit, stop bit 1.
- FSM (all transitions occur only on a fall, except timeout):
  - IDLE: on a fall with data=0 -> DATA, bit counter cleared. A fall with data=1 is ignored.
  - DATA: shift the sampled bit into shreg[7] (right shift). After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: -> IDLE.
    - If stop=1 and ^{shreg, parity}=1: set code=shreg and pulse code_valid on the next clk (latency 1 clk after the stop-bit fall), then run the decode step below.
    - Otherwise: pulse frame_err, do not update code, do not decode.
- Timeout: the counter resets on every fall and while in IDLE. If it reaches TIMEOUT_CYCLES in DATA, PARITY or STOP, pulse frame_err once and go to IDLE. The break_pend and ext_pend flags are cleared as well.
- Decode step (on a valid byte b):
  - b=E0: ext_pend=1.
  - b=F0: break_pend=1.
  - b other, break_pend=1: if b==current_data and ext_pend==extended, set current_data=0x00 and extended=0; otherwise no change. Clear both flags.
  - b other, break_pend=0: set current_data=b and extended=ext_pend, then clear ext_pend. A repeat (typematic) make of the same key rewrites the same value.
- code_valid and frame_err are never asserted in the same cycle. Each is high for exactly 1 clk.
- current_data is stable between decode events. Downstream samples it on the slower framerate tick with no handshake.

Test Plan:
- Reset, then one frame of 0x1D (parity bit 1, stop bit 1) at 12.5 kHz ps2_clk -> code=0x1D, exactly one code_valid pulse 1 clk after the stop-bit fall, current_data=0x1D, extended=0.
- After the 0x1D make, frames F0 then 1D -> two code_valid pulses; current_data returns to 0x00.
- Make 0x1D, then break F0 0x1B -> current_data stays 0x1D. Then E0 75 -> current_data=0x75, extended=1. Then E0 F0 75 -> current_data=0x00, extended=0.
- Frame 0x1B with parity bit forced to 0 -> frame_err single pulse, code and current_data unchanged. Next frame with stop bit 0 -> frame_err, no code_valid.
- Start bit plus 3 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES clks after the last fall, state IDLE. A subsequent good 0x1D frame decodes correctly.
- A 2-clk low glitch on ps2_clk in IDLE produces no state change. Reset asserted mid-frame after 5 data bits yields all outputs 0, and the next full frame decodes correctly.
